// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage owning the PC, driving imem and loading the IF/ID register
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_PC   = 32'h0000_00FC,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        halted,
   output logic [31:0] fetch_count
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, count_q, count_d;
   logic        valid_q, valid_d, halted_q, halted_d;
   logic [31:0] pc_plus4;
   assign pc_plus4    = pc_q + 32'd4;
   assign imem_addr   = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;
   assign halted      = halted_q;
   assign fetch_count = count_q;
   // next-state: redirect beats stall beats halt check beats sequential fetch; BOOT and HALT only bubble
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc4_d    = pc4_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      count_d  = count_q;
      if (state_q != RUN) begin
         instr_d = NOP_INSTR;
         pc4_d   = '0;
         valid_d = 1'b0;
         state_d = (state_q == BOOT) ? RUN : HALT;
      end else if (redirect) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         instr_d = NOP_INSTR;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (pc_q == HALT_PC) begin
         instr_d  = NOP_INSTR;
         pc4_d    = '0;
         valid_d  = 1'b0;
         halted_d = 1'b1;
         state_d  = HALT;
      end else begin
         instr_d = imem_instr;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
         pc_d    = pc_plus4;
         count_d = count_q + 32'd1;
      end
   end
   // state, PC and IF/ID registers with asynchronous reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= BOOT;
         pc_q     <= {RESET_PC[31:2], 2'b00};
         instr_q  <= NOP_INSTR;
         pc4_q    <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc4_q    <= pc4_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         count_q  <= count_d;
      end
   end
endmodule
